pb_conditioner: RTL and testbench

- Upstream input stage for the ice40 simulator top: sits between the raw push-button vector and the student `top` `pb` input.
- Synchronises, debounces and edge-detects all 21 buttons on the hz100 clock.
- Also produces a registered keycode of the most recent press with a one-cycle strobe, so student designs can consume clean key events.

---
 rtl/ice40_pkg.sv | 18 +
 rtl/pb_debounce_bit.sv | 52 +++++
 rtl/pb_conditioner.sv | 61 ++++++
 tb/tb_pb_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ice40_pkg.sv
// Shared constants for the ice40 simulator top: button count, keycode width
// and names for the buttons that other blocks refer to by index.
package ice40_pkg;

    localparam int NUM_PB = 21;
    localparam int KEY_W  = $clog2(NUM_PB);

    // Buttons with a fixed meaning elsewhere (reset combo, corner keys).
    typedef enum logic [KEY_W-1:0] {
        PB_0  = 5'd0,
        PB_3  = 5'd3,
        PB_5  = 5'd5,
        PB_7  = 5'd7,
        PB_16 = 5'd16,
        PB_20 = 5'd20
    } pb_idx_e;

endpackage

// File: rtl/pb_debounce_bit.sv
// One button: two-flop synchroniser, hold-time debounce counter and
// registered rise/fall pulses aligned with the clean level change.
module pb_debounce_bit #(
    parameter int DEBOUNCE = 2
) (
    input  logic hz100,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic rise_next
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // clean flips on this edge once sync2 has disagreed for DEBOUNCE cycles
    assign flip      = (sync2 != clean) && (cnt == CNT_LAST);
    assign rise_next = flip & sync2;

    // NOTE: every register here uses <= so all flops sample pre-edge values.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            rise <= rise_next;
            fall <= flip & ~sync2;
        end
    end

endmodule

// File: rtl/pb_conditioner.sv
// Push-button input stage: per-bit debounce plus a keycode register holding
// the highest-index button of the most recent press, with a one-cycle strobe.
module pb_conditioner #(
    parameter int NUM_PB   = ice40_pkg::NUM_PB,
    parameter int DEBOUNCE = 2,
    parameter int KEY_W    = $clog2(NUM_PB)
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_clean,
    output logic [NUM_PB-1:0] pb_rise,
    output logic [NUM_PB-1:0] pb_fall,
    output logic [KEY_W-1:0]  keycode,
    output logic              keyvalid,
    output logic              anykey
);

    logic [NUM_PB-1:0] rise_next;
    logic [KEY_W-1:0]  top_idx;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE(DEBOUNCE)
        ) u_bit (
            .hz100    (hz100),
            .reset    (reset),
            .raw      (pb_raw[g]),
            .clean    (pb_clean[g]),
            .rise     (pb_rise[g]),
            .fall     (pb_fall[g]),
            .rise_next(rise_next[g])
        );
    end

    // NOTE: default first so no path through this block leaves top_idx unassigned.
    always_comb begin
        top_idx = '0;
        // ascending scan: the last hit, i.e. the highest index, wins
        for (int i = 0; i < NUM_PB; i++) begin
            if (rise_next[i]) begin
                top_idx = KEY_W'(i);
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            keycode  <= '0;
            keyvalid <= 1'b0;
        end else begin
            keyvalid <= |rise_next;
            if (|rise_next) begin
                keycode <= top_idx;
            end
        end
    end

    assign anykey = |pb_clean;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench: a table of {raw, expected outputs} rows for the main
// DEBOUNCE=2 instance, plus hand-written async-reset and DEBOUNCE=1 sequences.
module tb_pb_conditioner;
    import ice40_pkg::*;

    localparam logic [20:0] ALL = 21'h1FFFFF;

    typedef struct packed {
        logic [20:0] clean;
        logic [20:0] rise;
        logic [20:0] fall;
        logic [4:0]  kc;
        logic        kv;
        logic        ak;
    } out_t;

    typedef struct {
        string       name;
        logic [20:0] raw;
        out_t        exp;
    } vec_t;

    logic        hz100;
    logic        reset;
    logic [20:0] pb_raw,   pb_raw2;
    logic [20:0] pb_clean, pb_clean2;
    logic [20:0] pb_rise,  pb_rise2;
    logic [20:0] pb_fall,  pb_fall2;
    logic [4:0]  keycode,  keycode2;
    logic        keyvalid, keyvalid2;
    logic        anykey,   anykey2;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    pb_conditioner #(.DEBOUNCE(2)) dut (
        .hz100(hz100), .reset(reset), .pb_raw(pb_raw),
        .pb_clean(pb_clean), .pb_rise(pb_rise), .pb_fall(pb_fall),
        .keycode(keycode), .keyvalid(keyvalid), .anykey(anykey)
    );

    pb_conditioner #(.DEBOUNCE(1)) dut1 (
        .hz100(hz100), .reset(reset), .pb_raw(pb_raw2),
        .pb_clean(pb_clean2), .pb_rise(pb_rise2), .pb_fall(pb_fall2),
        .keycode(keycode2), .keyvalid(keyvalid2), .anykey(anykey2)
    );

    initial begin
        hz100 = 1'b0;
        forever #5 hz100 = ~hz100;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(logic [20:0] c, logic [20:0] r, logic [20:0] f,
                                logic [4:0] k, logic v, logic a);
        out_t o;
        o.clean = c; o.rise = r; o.fall = f; o.kc = k; o.kv = v; o.ak = a;
        return o;
    endfunction

    function automatic out_t cur1();
        return mk(pb_clean, pb_rise, pb_fall, keycode, keyvalid, anykey);
    endfunction

    function automatic out_t cur2();
        return mk(pb_clean2, pb_rise2, pb_fall2, keycode2, keyvalid2, anykey2);
    endfunction

    function automatic void add(string n, logic [20:0] raw, logic [20:0] c,
                                logic [20:0] r, logic [20:0] f, logic [4:0] k,
                                logic v, logic a);
        vec_t e;
        e.name = n; e.raw = raw; e.exp = mk(c, r, f, k, v, a);
        vecs.push_back(e);
    endfunction

    task automatic check(string n, out_t act, out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got clean=%h rise=%h fall=%h key=%0d kv=%b any=%b; want clean=%h rise=%h fall=%h key=%0d kv=%b any=%b",
                     n, act.clean, act.rise, act.fall, act.kc, act.kv, act.ak,
                     exp.clean, exp.rise, exp.fall, exp.kc, exp.kv, exp.ak);
        end
    endtask

    // entered and left on a falling edge; raw is applied before the next rising edge
    task automatic apply(string n, logic [20:0] raw, out_t exp);
        pb_raw = raw;
        @(posedge hz100);
        #1;
        check(n, cur1(), exp);
        @(negedge hz100);
    endtask

    initial begin
        // test 1: all buttons held through reset
        add("t1_e0", ALL, 0, 0, 0, 0, 0, 0);
        add("t1_e1", ALL, 0, 0, 0, 0, 0, 0);
        add("t1_e2", ALL, 0, 0, 0, 0, 0, 0);
        add("t1_e3", ALL, ALL, ALL, 0, PB_20, 1, 1);
        add("t1_e4", ALL, ALL, 0, 0, PB_20, 0, 1);
        for (int i = 0; i < 3; i++) add("idle_wait", 0, ALL, 0, 0, PB_20, 0, 1);
        add("idle_fall", 0, 0, 0, ALL, PB_20, 0, 0);
        add("idle_done", 0, 0, 0, 0, PB_20, 0, 0);
        // test 2: one-cycle glitch on bit 5 rejected, then a real press
        add("t2_glitch", 21'h20, 0, 0, 0, PB_20, 0, 0);
        for (int i = 0; i < 3; i++) add("t2_glitch_gone", 0, 0, 0, 0, PB_20, 0, 0);
        for (int i = 0; i < 3; i++) add("t2_hold_wait", 21'h20, 0, 0, 0, PB_20, 0, 0);
        add("t2_press", 21'h20, 21'h20, 21'h20, 0, PB_5, 1, 1);
        add("t2_held", 21'h20, 21'h20, 0, 0, PB_5, 0, 1);
        // test 3: release bit 5, keycode holds
        for (int i = 0; i < 3; i++) add("t3_wait", 0, 21'h20, 0, 0, PB_5, 0, 1);
        add("t3_fall", 0, 0, 0, 21'h20, PB_5, 0, 0);
        add("t3_after", 0, 0, 0, 0, PB_5, 0, 0);
        // test 4: bits 3 and 16 together, highest index wins
        for (int i = 0; i < 3; i++) add("t4_wait", 21'h10008, 0, 0, 0, PB_5, 0, 0);
        add("t4_press", 21'h10008, 21'h10008, 21'h10008, 0, PB_16, 1, 1);
        add("t4_held", 21'h10008, 21'h10008, 0, 0, PB_16, 0, 1);
        // bit 3 falls while bit 7 rises on the same edge
        for (int i = 0; i < 3; i++) add("mix_wait", 21'h10080, 21'h10008, 0, 0, PB_16, 0, 1);
        add("mix_edge", 21'h10080, 21'h10080, 21'h80, 21'h8, PB_7, 1, 1);
        add("mix_after", 21'h10080, 21'h10080, 0, 0, PB_7, 0, 1);
        // set up test 5: bit 7 released, then pressed again into mid-count
        for (int i = 0; i < 3; i++) add("t5_rel_wait", 21'h10000, 21'h10080, 0, 0, PB_7, 0, 1);
        add("t5_rel_fall", 21'h10000, 21'h10000, 0, 21'h80, PB_7, 0, 1);
        add("t5_rel_done", 21'h10000, 21'h10000, 0, 0, PB_7, 0, 1);
        for (int i = 0; i < 3; i++) add("t5_counting", 21'h10080, 21'h10000, 0, 0, PB_7, 0, 1);

        pb_raw  = ALL;
        pb_raw2 = '0;
        reset   = 1'b1;
        #2;
        check("reset_async", cur1(), '0);
        check("reset_async_d1", cur2(), '0);
        repeat (2) @(posedge hz100);
        #1;
        check("reset_held", cur1(), '0);
        @(negedge hz100);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i].name, vecs[i].raw, vecs[i].exp);

        // test 5: async reset between clocks while bit 7 is mid-count
        reset = 1'b1;
        #1;
        check("t5_reset_now", cur1(), '0);
        @(posedge hz100);
        #1;
        check("t5_reset_held", cur1(), '0);
        @(negedge hz100);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) apply("t5_redetect_wait", 21'h80, '0);
        apply("t5_redetect", 21'h80, mk(21'h80, 21'h80, 0, PB_7, 1, 1));
        apply("t5_redetect_held", 21'h80, mk(21'h80, 0, 0, PB_7, 0, 1));

        // test 6: DEBOUNCE=1 instance, one-cycle raw pulse on bit 0
        check("t6_idle", cur2(), '0);
        pb_raw2 = 21'h1;
        @(posedge hz100);
        #1;
        check("t6_e0", cur2(), '0);
        @(negedge hz100);
        pb_raw2 = '0;
        @(posedge hz100);
        #1;
        check("t6_e1", cur2(), '0);
        @(posedge hz100);
        #1;
        check("t6_e2_rise", cur2(), mk(21'h1, 21'h1, 0, PB_0, 1, 1));
        @(posedge hz100);
        #1;
        check("t6_e3_fall", cur2(), mk(0, 0, 21'h1, PB_0, 0, 0));
        @(posedge hz100);
        #1;
        check("t6_e4_quiet", cur2(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
